// File: rtl/i2c_reg_controller_if.sv
// Bus bundle between the I2C register controller and its neighbours:
// the I2C slave core byte stream plus the local host register port.
interface i2c_reg_controller_if #(
    parameter int ADDR_W = 4
);
    logic [6:0]        address;
    logic [7:0]        datareceive;
    logic              received;
    logic [7:0]        datasend;
    logic              sended;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic [7:0]        host_rdata;
    logic              host_ack;
    logic              i2c_wr;
    logic [ADDR_W-1:0] i2c_wr_addr;

    modport slave (
        output address, datasend, host_rdata, host_ack, i2c_wr, i2c_wr_addr,
        input  datareceive, received, sended, host_req, host_we, host_addr, host_wdata
    );

    modport master (
        input  address, datasend, host_rdata, host_ack, i2c_wr, i2c_wr_addr,
        output datareceive, received, sended, host_req, host_we, host_addr, host_wdata
    );
endinterface

// File: rtl/i2c_reg_controller.sv
// Byte register file behind the I2C slave core: pointer-then-data writes,
// auto-incrementing reads, and a host port that yields to I2C writes.
module i2c_reg_controller #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h27,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] DEV_ID       = 8'hA5,
    parameter int         IDLE_TIMEOUT = 1000,
    parameter int         CNT_W        = 10
) (
    input  logic                clk,
    input  logic                reset,
    i2c_reg_controller_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        regs_q [NREG];
    logic [7:0]        datasend_q;
    logic [7:0]        host_rdata_q;
    logic              host_ack_q;
    logic              i2c_wr_q;
    logic [ADDR_W-1:0] i2c_wr_addr_q;

    logic              i2c_we;
    logic              host_wr_grant;
    logic              host_rd;
    logic              timeout_hit;
    logic [NREG-1:0]   reg_we;
    logic [7:0]        reg_wdata_d;

    // Register 0 is the device ID, so an I2C byte aimed at it is not a write
    // and must not stall the host.
    assign i2c_we        = (state_q == WRITE) && bus.received && (ptr_q != '0);
    // The ack cycle is skipped so one request yields exactly one ack.
    assign host_wr_grant = bus.host_req && bus.host_we && !host_ack_q && !i2c_we;
    assign host_rd       = bus.host_req && !bus.host_we && !host_ack_q;
    assign timeout_hit   = (cnt_q == CNT_W'(IDLE_TIMEOUT - 1));
    assign reg_wdata_d   = i2c_we ? bus.datareceive : bus.host_wdata;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_we
            if (gi == 0) begin : g_ro
                assign reg_we[gi] = 1'b0;
            end else begin : g_rw
                assign reg_we[gi] = (i2c_we && (ptr_q == ADDR_W'(gi))) ||
                                    (host_wr_grant && (bus.host_addr == ADDR_W'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 0) ? DEV_ID : 8'h00;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_we[i]) begin
                    regs_q[i] <= reg_wdata_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            datasend_q    <= DEV_ID;
            host_rdata_q  <= 8'h00;
            host_ack_q    <= 1'b0;
            i2c_wr_q      <= 1'b0;
            i2c_wr_addr_q <= '0;
        end else begin
            i2c_wr_q   <= 1'b0;
            datasend_q <= regs_q[ptr_q];
            host_ack_q <= host_rd || host_wr_grant;
            if (host_rd) begin
                host_rdata_q <= regs_q[bus.host_addr];
            end

            // A received byte outranks a simultaneous sended pulse everywhere.
            case (state_q)
                IDLE: begin
                    if (bus.received) begin
                        ptr_q   <= bus.datareceive[ADDR_W-1:0];
                        state_q <= WRITE;
                    end else if (bus.sended) begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= READ;
                    end
                end
                WRITE: begin
                    if (bus.received) begin
                        if (i2c_we) begin
                            i2c_wr_q      <= 1'b1;
                            i2c_wr_addr_q <= ptr_q;
                        end
                        ptr_q <= ptr_q + 1'b1;
                    end else if (bus.sended) begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (bus.received) begin
                        ptr_q   <= bus.datareceive[ADDR_W-1:0];
                        state_q <= WRITE;
                    end else if (bus.sended) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Silence on the bus ends the transaction; the pointer survives.
            if (state_q == IDLE || bus.received || bus.sended) begin
                cnt_q <= '0;
            end else if (timeout_hit) begin
                cnt_q   <= '0;
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.address     = SLAVE_ADDR;
    assign bus.datasend    = datasend_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.i2c_wr      = i2c_wr_q;
    assign bus.i2c_wr_addr = i2c_wr_addr_q;
endmodule

// File: tb/tb_i2c_reg_controller.sv
// Directed bench for the I2C register controller: I2C byte streams, host
// port accesses and their collisions, checked against hand-computed values.
module tb_i2c_reg_controller;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    i2c_reg_controller_if #(.ADDR_W(4)) bus();

    i2c_reg_controller #(
        .SLAVE_ADDR  (7'h27),
        .ADDR_W      (4),
        .DEV_ID      (8'hA5),
        .IDLE_TIMEOUT(1000),
        .CNT_W       (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        bus.datareceive = b;
        bus.received    = 1'b1;
        @(negedge clk);
        bus.received    = 1'b0;
        $display("rx byte=%h i2c_wr=%b i2c_wr_addr=%0d", b, bus.i2c_wr, bus.i2c_wr_addr);
    endtask

    task automatic tx();
        @(negedge clk);
        bus.sended = 1'b1;
        @(negedge clk);
        bus.sended = 1'b0;
        $display("tx datasend=%h", bus.datasend);
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat);
        @(negedge clk);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = wd;
        lat = -1;
        rd  = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.host_ack) begin
                lat = i;
                rd  = bus.host_rdata;
                break;
            end
        end
        bus.host_req = 1'b0;
        $display("host we=%b addr=%0d wdata=%h rdata=%h latency=%0d", we, a, wd, rd, lat);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int lat;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.address !== 7'h27) begin errors++; $display("FAIL reset_address got=%h exp=27", bus.address); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.datasend !== 8'hA5) begin errors++; $display("FAIL reset_datasend got=%h exp=a5", bus.datasend); end
        checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack got=%b exp=0", bus.host_ack); end
        checks++; if (bus.i2c_wr !== 1'b0) begin errors++; $display("FAIL reset_i2c_wr got=%b exp=0", bus.i2c_wr); end
        checks++; if (bus.host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata got=%h exp=00", bus.host_rdata); end
        host_op(1'b1, 4'd0, 8'h3C, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL reg0_write_ack latency got=%0d exp=1", lat); end
        host_op(1'b0, 4'd0, 8'h00, rd, lat);
        checks++; if (rd !== 8'hA5 || lat !== 1) begin errors++; $display("FAIL reg0_readback got=%h lat=%0d exp=a5 lat=1", rd, lat); end
    endtask

    task automatic test_i2c_write();
        logic [7:0] rd;
        int lat;
        rx(8'h03);
        checks++; if (bus.i2c_wr !== 1'b0) begin errors++; $display("FAIL ptr_byte_no_wr got=%b exp=0", bus.i2c_wr); end
        rx(8'h11);
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd3) begin errors++; $display("FAIL wr_reg3 got wr=%b addr=%0d exp wr=1 addr=3", bus.i2c_wr, bus.i2c_wr_addr); end
        rx(8'h22);
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd4) begin errors++; $display("FAIL wr_reg4 got wr=%b addr=%0d exp wr=1 addr=4", bus.i2c_wr, bus.i2c_wr_addr); end
        @(negedge clk);
        checks++; if (bus.i2c_wr !== 1'b0) begin errors++; $display("FAIL wr_pulse_width got=%b exp=0", bus.i2c_wr); end
        checks++; if (dut.ptr_q !== 4'd5) begin errors++; $display("FAIL ptr_after_write got=%0d exp=5", dut.ptr_q); end
        host_op(1'b0, 4'd3, 8'h00, rd, lat);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL reg3_value got=%h exp=11", rd); end
        host_op(1'b0, 4'd4, 8'h00, rd, lat);
        checks++; if (rd !== 8'h22) begin errors++; $display("FAIL reg4_value got=%h exp=22", rd); end
    endtask

    task automatic test_pointer_read();
        tx();
        rx(8'h03);
        checks++; if (bus.i2c_wr !== 1'b0) begin errors++; $display("FAIL read_state_ptr_no_wr got=%b exp=0", bus.i2c_wr); end
        repeat (2) @(negedge clk);
        checks++; if (bus.datasend !== 8'h11) begin errors++; $display("FAIL datasend_reg3 got=%h exp=11", bus.datasend); end
        tx();
        repeat (2) @(negedge clk);
        checks++; if (bus.datasend !== 8'h22) begin errors++; $display("FAIL datasend_reg4 got=%h exp=22", bus.datasend); end
    endtask

    task automatic test_wrap();
        logic [7:0] rd;
        int lat;
        rx(8'h0F);
        checks++; if (bus.i2c_wr !== 1'b0 || dut.ptr_q !== 4'd15) begin errors++; $display("FAIL read_to_pointer got wr=%b ptr=%0d exp wr=0 ptr=15", bus.i2c_wr, dut.ptr_q); end
        rx(8'h77);
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd15) begin errors++; $display("FAIL wr_reg15 got wr=%b addr=%0d exp wr=1 addr=15", bus.i2c_wr, bus.i2c_wr_addr); end
        rx(8'h88);
        checks++; if (bus.i2c_wr !== 1'b0) begin errors++; $display("FAIL reg0_no_wr_pulse got=%b exp=0", bus.i2c_wr); end
        checks++; if (dut.ptr_q !== 4'd1) begin errors++; $display("FAIL ptr_wrap got=%0d exp=1", dut.ptr_q); end
        host_op(1'b0, 4'd15, 8'h00, rd, lat);
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL reg15_value got=%h exp=77", rd); end
        host_op(1'b0, 4'd0, 8'h00, rd, lat);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL reg0_after_i2c got=%h exp=a5", rd); end
    endtask

    task automatic test_collision();
        logic [7:0] rd;
        int lat;
        tx();
        rx(8'h05);
        @(negedge clk);
        bus.datareceive = 8'h66;
        bus.received    = 1'b1;
        bus.host_req    = 1'b1;
        bus.host_we     = 1'b1;
        bus.host_addr   = 4'd5;
        bus.host_wdata  = 8'h55;
        @(negedge clk);
        bus.received = 1'b0;
        checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL collision_stall got ack=%b exp=0", bus.host_ack); end
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd5) begin errors++; $display("FAIL collision_i2c got wr=%b addr=%0d exp wr=1 addr=5", bus.i2c_wr, bus.i2c_wr_addr); end
        @(negedge clk);
        checks++; if (bus.host_ack !== 1'b1) begin errors++; $display("FAIL collision_late_ack got=%b exp=1", bus.host_ack); end
        bus.host_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL collision_single_ack got=%b exp=0", bus.host_ack); end
        $display("collision host wdata=55 i2c wdata=66 addr=5");
        host_op(1'b0, 4'd5, 8'h00, rd, lat);
        checks++; if (rd !== 8'h55) begin errors++; $display("FAIL collision_final got=%h exp=55", rd); end
        host_op(1'b1, 4'd6, 8'h5A, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL free_write_latency got=%0d exp=1", lat); end
        host_op(1'b0, 4'd6, 8'h00, rd, lat);
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL free_write_value got=%h exp=5a", rd); end
    endtask

    task automatic test_timeout();
        logic [7:0] rd;
        int lat;
        tx();
        rx(8'h02);
        repeat (999) @(negedge clk);
        checks++; if (dut.state_q !== 2'd1) begin errors++; $display("FAIL before_timeout got state=%0d exp=1", dut.state_q); end
        @(negedge clk);
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL at_timeout got state=%0d exp=0", dut.state_q); end
        rx(8'h06);
        checks++; if (bus.i2c_wr !== 1'b0 || dut.ptr_q !== 4'd6) begin errors++; $display("FAIL post_timeout_ptr got wr=%b ptr=%0d exp wr=0 ptr=6", bus.i2c_wr, dut.ptr_q); end
        host_op(1'b0, 4'd2, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reg2_untouched got=%h exp=00", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        int lat;
        @(negedge clk);
        bus.datareceive = 8'hAA;
        bus.received    = 1'b1;
        @(negedge clk);
        bus.datareceive = 8'hBB;
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd6) begin errors++; $display("FAIL b2b_first got wr=%b addr=%0d exp wr=1 addr=6", bus.i2c_wr, bus.i2c_wr_addr); end
        @(negedge clk);
        bus.received = 1'b0;
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd7) begin errors++; $display("FAIL b2b_second got wr=%b addr=%0d exp wr=1 addr=7", bus.i2c_wr, bus.i2c_wr_addr); end
        $display("back-to-back rx bytes=aa,bb");
        host_op(1'b0, 4'd6, 8'h00, rd, lat);
        checks++; if (rd !== 8'hAA) begin errors++; $display("FAIL b2b_reg6 got=%h exp=aa", rd); end
        host_op(1'b0, 4'd7, 8'h00, rd, lat);
        checks++; if (rd !== 8'hBB) begin errors++; $display("FAIL b2b_reg7 got=%h exp=bb", rd); end
        @(negedge clk);
        bus.datareceive = 8'hCC;
        bus.received    = 1'b1;
        bus.sended      = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        bus.sended   = 1'b0;
        $display("rx+tx same cycle byte=cc");
        checks++; if (bus.i2c_wr !== 1'b1 || bus.i2c_wr_addr !== 4'd8) begin errors++; $display("FAIL rx_over_tx got wr=%b addr=%0d exp wr=1 addr=8", bus.i2c_wr, bus.i2c_wr_addr); end
        checks++; if (dut.ptr_q !== 4'd9 || dut.state_q !== 2'd1) begin errors++; $display("FAIL rx_over_tx_state got ptr=%0d state=%0d exp ptr=9 state=1", dut.ptr_q, dut.state_q); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] rd;
        int lat;
        @(negedge clk);
        bus.datareceive = 8'hDD;
        bus.received    = 1'b1;
        reset           = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        reset        = 1'b0;
        $display("reset during rx byte=dd");
        checks++; if (bus.i2c_wr !== 1'b0 || bus.datasend !== 8'hA5) begin errors++; $display("FAIL abort_outputs got wr=%b datasend=%h exp wr=0 datasend=a5", bus.i2c_wr, bus.datasend); end
        host_op(1'b0, 4'd9, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL abort_reg9 got=%h exp=00", rd); end
    endtask

    initial begin
        reset           = 1'b1;
        bus.datareceive = 8'h00;
        bus.received    = 1'b0;
        bus.sended      = 1'b0;
        bus.host_req    = 1'b0;
        bus.host_we     = 1'b0;
        bus.host_addr   = 4'd0;
        bus.host_wdata  = 8'h00;
        test_reset();
        test_i2c_write();
        test_pointer_read();
        test_wrap();
        test_collision();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
